// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues one-cycle-latency
// reads to instruction memory and buffers responses in a 2-entry skid FIFO.
module fetch_unit #(
  parameter int                  ADDR_W   = 10,
  parameter int                  DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [DATA_W-1:0] insn_in,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_insn,
  output logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_ready
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] insn;
  } entry_t;

  logic [ADDR_W-1:0] pc_reg;
  logic              req_valid;
  logic [ADDR_W-1:0] req_pc;

  entry_t            fifo [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              push;
  logic              pop;
  logic [2:0]        occ_next;
  logic              issue;

  // The response of the read in flight is always accepted unless a redirect
  // kills it; issue is throttled on the post-update occupancy so that the
  // FIFO can never be asked to hold a third entry.
  always_comb begin
    push     = req_valid && !redirect_valid;
    pop      = fetch_valid && fetch_ready;
    occ_next = 3'(count) + 3'(push) - 3'(pop);
    issue    = fetch_en && !redirect_valid && (occ_next < 3'd2);
  end

  assign pc_out      = pc_reg;
  assign fetch_valid = (count != 2'd0);
  assign fetch_insn  = fifo[rd_ptr].insn;
  assign fetch_pc    = fifo[rd_ptr].pc;

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the pre-edge values; blocking writes would let later
  // statements in this block see half-updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      req_valid <= 1'b0;
      req_pc    <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      // NOTE: the storage array is cleared too, because the head entry is
      // visible on fetch_insn/fetch_pc and must read as zero after reset.
      for (int i = 0; i < 2; i++) begin
        fifo[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc_reg    <= redirect_pc;
      req_valid <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{pc: req_pc, insn: insn_in};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count     <= occ_next[1:0];
      req_valid <= issue;
      if (issue) begin
        req_pc <= pc_reg;
        pc_reg <= pc_reg + ADDR_W'(1);
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter, drives the 10-bit word index into the memory, and captures the instruction returned one clock later into a 2-entry skid buffer. The buffer presents {pc, instruction} to decode over a valid/ready handshake. Branch and jump redirects flush all fetched-but-unconsumed work.

## Interface
- ADDR_W, 10, word-index width; matches the 1024-entry instruction memory
- DATA_W, 32, instruction width
- RESET_PC, 0, word index fetched first after reset
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- pc_out  out  ADDR_W  word index driven to the instruction memory
- insn_in  in  DATA_W  instruction memory output; holds mem[pc_out] as sampled at the previous rising edge
- fetch_en  in  1  enables new fetch issue; does not affect draining
- redirect_valid  in  1  one-cycle pulse that redirects fetch
- redirect_pc  in  ADDR_W  redirect target word index
- fetch_valid  out  1  buffer head holds a valid instruction
- fetch_insn  out  DATA_W  buffer head instruction
- fetch_pc  out  ADDR_W  word index of fetch_insn
- fetch_ready  in  1  decode accepts the head this cycle

## Operation
- State:
  - pc_reg (pc_out = pc_reg, registered)
  - req_valid and req_pc, which mark an in-flight read
  - 2-entry FIFO of {pc, insn} with rd_ptr, wr_ptr and count (0..2)
- Response: when req_valid=1, insn_in equals mem[req_pc] in that same cycle, so push = req_valid && !redirect_valid.
- Pop: pop = fetch_valid && fetch_ready.
- Occupancy: occ_next = count + push - pop.
- Issue: issue = fetch_en && !redirect_valid && occ_next < 2.
  - On issue: req_valid<=1, req_pc<=pc_reg, pc_reg<=pc_reg+1 (modulo 2^ADDR_W; 1023 wraps to 0).
  - Otherwise: req_valid<=0 and pc_reg holds.
- Outputs: fetch_valid = (count != 0). fetch_insn and fetch_pc come straight from the FIFO head; there is no bypass from insn_in.
- Redirect (redirect_valid=1):
  - count, rd_ptr and wr_ptr go to 0.
  - req_valid<=0, and this cycle's response is dropped.
  - pc_reg<=redirect_pc. No issue is made this cycle.
  - A handshake completing in the same cycle still counts as delivered.
- Simultaneous push and pop with count=2 is impossible, because issue is gated by occ_next.
- Simultaneous push and pop with count=1 leaves count=1.
- The pop path is combinational: fetch_ready reaches issue. This is accepted.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - pc_reg=RESET_PC, req_valid=0, count=0, pointers=0
  - FIFO storage=0, so fetch_valid=0, fetch_insn=0, fetch_pc=0 and pc_out=RESET_PC
- Reset overrides redirect and every other input.
- Reset mid-operation discards all buffered and in-flight instructions.
- First release from reset (cycle 0 = first cycle with rst_n=1, fetch_en=1):
  - issue of RESET_PC in cycle 0
  - push in cycle 1
  - fetch_valid=1 with fetch_pc=RESET_PC in cycle 2
- Redirect in cycle R:
  - pc_out=redirect_pc in R+1 (issue)
  - push in R+2
  - fetch_valid with fetch_pc=redirect_pc in R+3
- No instruction issued before R is ever delivered after R.
- Steady state with fetch_ready=1: one instruction per cycle, with count oscillating at 1.
- Backpressure: issue stops once two instructions are buffered or in flight, and nothing is lost or duplicated.
- fetch_en low: any in-flight read still pushes, and the buffer drains normally.

## Test plan
- Reset, then fetch_en=1 and fetch_ready=1, with mem[i]=0x1000_0000+i -> from cycle 2, fetch_pc=0,1,2,3... every cycle and fetch_insn=0x1000_0000+fetch_pc.
- Hold fetch_ready=0 for 6 cycles mid-stream -> count saturates at 2 and pc_out stops two past the head. After release, the pc sequence continues contiguously with no gap or repeat.
- Redirect to 0x200 while count=2 and req_valid=1 -> the next delivered fetch_pc is 0x200 exactly at R+3, with no stale pc delivered in between.
- Redirect to 1022 -> delivered fetch_pc is 1022, 1023, 0, 1 (wrap-around).
- redirect_valid=1 in the same cycle as rst_n=0 -> after release, the first delivered fetch_pc=RESET_PC.
- fetch_en dropped with count=1 and req_valid=1 -> exactly 2 more instructions are delivered, then fetch_valid=0 and pc_out is frozen.
